// File: rtl/grant_arb_pkg.sv
// rtl/grant_arb_pkg.sv - shared types and constants for the 4-way grant arbiter
//
// Holds the arbiter FSM state type, the requester count, the default hold limit
// and a small index-to-one-hot helper shared by the arbiter files.
package grant_arb_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin winner select over four requesters
//
// Ports:
//   req       [3:0] in   request lines, bit i = requester i
//   last_id   [1:0] in   index of the most recently released grantee
//   found           out  high when any req bit is set
//   winner_id [1:0] out  first set req bit searching from last_id+1 upward,
//                        wrapping 3 -> 0; last_id itself is tried last
module rr_pick4
  import grant_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_id,
  output logic               found,
  output logic [1:0]         winner_id
);

  logic [1:0] cand;

  // Offsets 1..4 from last_id; the 2-bit add wraps, so offset 4 lands back on
  // last_id and a lone persistent requester is still served.
  always_comb begin
    found     = 1'b0;
    winner_id = last_id;
    cand      = last_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_id + 2'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        winner_id = cand;
      end
    end
  end

endmodule

// File: rtl/grant_arbiter_4.sv
// rtl/grant_arbiter_4.sv - 4-requester round-robin grant arbiter with hold limit
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   req       [3:0] in   level-sensitive requests, bit i = requester i
//   gnt       [3:0] out  registered grant, one-hot or zero
//   gnt_valid       out  registered, high exactly when gnt is non-zero
//   gnt_id    [1:0] out  registered grantee index, holds last value when idle
//   any_req         out  registered OR of req, one cycle latency
//   timeout         out  one-cycle pulse when a grant is force-released
module grant_arbiter_4
  import grant_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [1:0]         gnt_id,
  output logic               any_req,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               any_req_q, any_req_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [1:0]         last_id_q, last_id_d;

  logic               pick_found;
  logic [1:0]         pick_id;

  rr_pick4 u_pick (
    .req       (req),
    .last_id   (last_id_q),
    .found     (pick_found),
    .winner_id (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      any_req_q   <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
      // Last grantee looks like requester 3 so requester 0 has first priority.
      last_id_q   <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      any_req_q   <= any_req_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    any_req_d   = |req;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          gnt_d       = id_to_onehot(pick_id);
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_id;
          hold_cnt_d  = 8'd1;
        end
      end

      ST_GRANT: begin
        // A dropped request is checked first so that a drop coinciding with
        // the hold limit is a normal release, not a timeout.
        if (!req[gnt_id_q]) begin
          state_d     = ST_RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          last_id_d   = gnt_id_q;
        end else if (hold_cnt_q >= HOLD_LIMIT) begin
          state_d     = ST_RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          last_id_d   = gnt_id_q;
          timeout_d   = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = 8'd0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign any_req   = any_req_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/grant_arbiter_4.md
GRANT_ARBITER_4 -- requirements
Module: grant_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum number of cycles one grant is held before forced release; legal range 2..255.
REQ-002 clk  input  1  single clock for all sequential logic; rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  request lines, one per requester, level-sensitive, bit i = requester i.
REQ-005 gnt  output  4  registered grant vector; one-hot or all-zero.
REQ-006 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-007 gnt_id  output  2  registered index of the granted requester; holds the last granted index while gnt_valid is low.
REQ-008 any_req  output  1  registered OR of req[3:0], one cycle latency.
REQ-009 timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 FSM has three states: IDLE, GRANT, RELEASE; the encoding is internal.
REQ-011 IDLE: if req != 0, select the winner by round-robin and go to GRANT; gnt is asserted on the next clock edge, giving 1-cycle latency from req to gnt.
REQ-012 Round-robin: search order starts at (last_id+1) mod 4 and wraps through 3 to 0; the first set req bit wins.
REQ-013 GRANT: gnt[gnt_id] stays high while req[gnt_id] is high and hold_cnt < MAX_HOLD.
REQ-014 hold_cnt is 8 bits; it loads 1 on entry to GRANT and increments each GRANT cycle; it must never wrap.
REQ-015 GRANT -> RELEASE when req[gnt_id] drops; gnt clears on the next edge; last_id <= gnt_id.
REQ-016 GRANT -> RELEASE when hold_cnt == MAX_HOLD and req[gnt_id] is still high; timeout pulses high for the same cycle in which gnt clears; last_id <= gnt_id.
REQ-017 If req drops and hold_cnt reaches MAX_HOLD in the same cycle, the drop wins and timeout stays 0.
REQ-018 RELEASE: lasts one cycle with gnt = 0, then returns to IDLE; requests seen during RELEASE are arbitrated in IDLE.
REQ-019 Changes to non-granted req bits during GRANT have no effect on gnt.
REQ-020 A timed-out requester that is still requesting is re-granted only after every other pending requester, as follows from the round-robin order.
REQ-021 gnt never has more than one bit set, and is never non-zero outside GRANT.

Reset
REQ-022 While rst_n = 0: state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, any_req = 0, timeout = 0, hold_cnt = 0, last_id = 3, so requester 0 has first priority.
REQ-023 If reset asserts mid-grant, all outputs clear immediately (asynchronously); with req held, the first grant after release goes to the lowest set bit.

Structure
REQ-024 A shared package grant_arb_pkg holds the state typedef, NUM_REQ = 4, and the default MAX_HOLD constant.
REQ-025 One sub-module, rr_pick4, is combinational and maps (req, last_id) to (found, winner_id); it is instantiated once.

Verification
REQ-026 Reset release with req = 4'b1010 -> on the first edge gnt = 4'b0010 and gnt_id = 1; any_req = 1 one cycle after req.
REQ-027 req = 4'b1111 held, with each grantee dropping its request after 2 cycles -> grant sequence 0,1,2,3,0, with one RELEASE cycle (gnt = 0) between each grant.
REQ-028 MAX_HOLD = 8, req = 4'b0100 held -> gnt = 4'b0100 for exactly 8 cycles, then timeout = 1 for one cycle with gnt = 0, then a re-grant to requester 2.
REQ-029 Requester 3 times out while req = 4'b1001 -> the next grant goes to requester 0, not 3.
REQ-030 rst_n pulsed low during a grant to requester 2, with req = 4'b0110 held -> outputs clear immediately; after release the grant goes to requester 1.
REQ-031 Random req for 10k cycles -> assertions hold that gnt is one-hot or zero, gnt_valid == |gnt, no grant exceeds MAX_HOLD cycles, and there is no starvation beyond 3 × (MAX_HOLD + 2) cycles.
